rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Consumes the S array left in s_RAM by the key-scheduling stage and runs the RC4 pseudo-random generation loop over it. For each message byte it XORs the keystream byte with the byte read from the encrypted-message ROM and writes the result to the decrypted-message RAM. It pulses `finish` when done and reports whether the plaintext looked valid. It sits after the KSA FSM and shares s_RAM with it through the top-level address/data mux.

## Interface

**Parameters**
- `MSG_LEN`, default 32: message length in bytes.
- `ADDR_W`, default 5: ROM and decrypted-RAM address width; must equal $clog2(MSG_LEN).

**Ports**
- `clock`  in  1: system clock.
- `i_reset`  in  1: reset, synchronous, active-high. Clock is `clock`.
- `start`  in  1: begin decryption; sampled only in IDLE.
- `finish`  out  1: one-cycle pulse on completion or abort.
- `key_valid`  out  1: registered plaintext-validity flag.
- `s_address`  out  8: s_RAM address.
- `s_data`  out  8: s_RAM write data.
- `s_wren`  out  1: s_RAM write enable.
- `s_q`  in  8: s_RAM read data.
- `rom_address`  out  ADDR_W: encrypted ROM address (equals k).
- `rom_q`  in  8: encrypted byte.
- `d_address`  out  ADDR_W: decrypted RAM address (equals k).
- `d_data`  out  8: decrypted byte.
- `d_wren`  out  1: decrypted RAM write enable.

## Operation

- **Algorithm.** i=0, j=0. For k = 0..MSG_LEN-1:
  - i = i+1
  - j = j+s[i]
  - swap s[i] and s[j]
  - f = s[s[i]+s[j]]
  - d[k] = f ^ enc[k]
- **Arithmetic.** i, j and the f-address are 8-bit and wrap mod 256. k is an ADDR_W+1 bit counter.
- **Registers.** i, j, k, si, sj, f (all 8-bit except k), plus `key_valid` and the state register.
- **Read latency.** RAM/ROM reads are synchronous. The address is held for two cycles and q is captured on the second (the _A/_B state pairs).
- **States:**
  - IDLE: go to INIT if `start`.
  - INIT: i, j, k ← 0; key_valid ← 1.
  - INC_I: i ← i+1.
  - RD_SI_A, RD_SI_B: s_address=i; si ← s_q in _B.
  - CALC_J: j ← j+si.
  - RD_SJ_A, RD_SJ_B: s_address=j; sj ← s_q in _B.
  - WR_I: s_address=i, s_data=sj, s_wren=1.
  - WR_J: s_address=j, s_data=si, s_wren=1.
  - RD_F_A, RD_F_B: s_address=si+sj; f ← s_q in _B. rom_address=k is held in every state.
  - WR_D: d_data=f^rom_q, d_wren=1.
  - CHECK: k ← k+1; go to DONE if k==MSG_LEN-1, else INC_I.
  - DONE: finish=1; go to IDLE.
- **Output decode.** Outputs are combinational decodes of the state register. Write enables are high in exactly one cycle per write.
- **start.** Ignored outside IDLE. A level held high restarts a new run after DONE, with i, j and k reset.
- **Reset.** Synchronous `i_reset` forces IDLE at any point, including mid-run. The next cycle has s_wren=d_wren=finish=0 and no further writes. S is left partially permuted, which is legal.
- **Reset values.** State IDLE; i=j=k=si=sj=f=0; key_valid=0; finish=0, s_wren=0, d_wren=0; s_address=0, s_data=0, rom_address=0, d_address=0, d_data=0.

## Timing

- 12 cycles per byte, from INC_I through CHECK.
- Counting the edge that samples `start` as edge 0: INIT follows edge 0, and DONE (finish=1) follows edge 12·MSG_LEN+1. For MSG_LEN=32 that is edge 385.
- The earliest new start is sampled in the IDLE cycle immediately after DONE.
- `key_valid` is stable from DONE until the next INIT.

## Configuration

- **Macro `RC4_PRGA_CHAR_CHECK_EN`, defined:**
  - In WR_D, a decrypted byte outside 0x61–0x7A and not 0x20 clears key_valid.
  - The write still occurs.
  - The next state is DONE instead of CHECK (early abort).
- **Not defined:** no check. key_valid stays 1 from INIT, and all MSG_LEN bytes are always written.

## Structure

- **Shared package `rc4_pkg`:**
  - state enum type `prga_state_t`
  - `RC4_S_SIZE`=256
  - `RC4_MSG_LEN_DEFAULT`=32
  - character bounds `RC4_CHAR_LO`=8'h61, `RC4_CHAR_HI`=8'h7A, `RC4_CHAR_SPACE`=8'h20
- **Sub-module:** combinational `rc4_char_check` (byte in, valid out), instantiated only under the macro. Everything else lives in one module.

## Test plan

- **Known keystream.** MSG_LEN=4, S preloaded identity, enc all 0x00.
  - d = 02,05,07,0D.
  - Final s[2]=03, s[3]=05, s[4]=09, s[5]=02, s[9]=04.
  - finish after edge 49.
- **Wrap-around.** Identity S except s[1]=0xFF, enc[0]=0x00.
  - j wraps to 0xFF; f-address (0xFF+0xFF)=0xFE.
  - d[0]=0xFE.
- **Full length.** MSG_LEN=32, random S and enc.
  - d matches the software model.
  - finish high exactly one cycle, after edge 385.
  - Exactly 64 s_wren and 32 d_wren pulses.
- **Start handling.** Pulse start again at edge 100 → ignored. Start held high through DONE → second run begins from i=j=k=0 and produces identical d for an unchanged S.
- **Mid-run reset.** Assert i_reset during byte 3 WR_I → next cycle all wrens and finish are 0, state IDLE, key_valid=0. A new start completes normally.
- **Macro, defined.** enc crafted so d[1]=0x41 → key_valid=0, finish after edge 24, d[2..] untouched.
- **Macro, not defined.** Same enc → all 32 bytes written, key_valid=1.

Source files
------------

// File: rtl/rc4_pkg.sv
// ----------------------------------------------------------------------------
// rc4_pkg - shared types and constants for the RC4 PRGA decrypt stage. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rc4_pkg;

  localparam int RC4_S_SIZE          = 256;
  localparam int RC4_S_ADDR_W        = $clog2(RC4_S_SIZE);
  localparam int RC4_MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] RC4_CHAR_LO    = 8'h61;
  localparam logic [7:0] RC4_CHAR_HI    = 8'h7A;
  localparam logic [7:0] RC4_CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_INC_I   = 4'd2,
    ST_RD_SI_A = 4'd3,
    ST_RD_SI_B = 4'd4,
    ST_CALC_J  = 4'd5,
    ST_RD_SJ_A = 4'd6,
    ST_RD_SJ_B = 4'd7,
    ST_WR_I    = 4'd8,
    ST_WR_J    = 4'd9,
    ST_RD_F_A  = 4'd10,
    ST_RD_F_B  = 4'd11,
    ST_WR_D    = 4'd12,
    ST_CHECK   = 4'd13,
    ST_DONE    = 4'd14
  } prga_state_t;

  // Plaintext alphabet accepted by the optional validity check.
  function automatic logic is_plain_char(input logic [7:0] b);
    return ((b >= RC4_CHAR_LO) && (b <= RC4_CHAR_HI)) || (b == RC4_CHAR_SPACE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_char_check.sv
// ----------------------------------------------------------------------------
// rc4_char_check - flags whether a decrypted byte is lowercase text or space.
// Used only when RC4_PRGA_CHAR_CHECK_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       valid
);

  assign valid = is_plain_char(char_in);

endmodule

`default_nettype wire

// File: rtl/rc4_prga_decrypt.sv
// ----------------------------------------------------------------------------
// rc4_prga_decrypt - RC4 PRGA over s_RAM, XOR-decrypts the message ROM into
// the decrypted RAM. Macro RC4_PRGA_CHAR_CHECK_EN: abort on non-text. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = RC4_MSG_LEN_DEFAULT,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              start,
  output logic              finish,
  output logic              key_valid,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren
);

  localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(MSG_LEN - 1);
  localparam logic [ADDR_W:0] K_ONE  = (ADDR_W+1)'(1);

  prga_state_t state;

  logic [RC4_S_ADDR_W-1:0] i;
  logic [RC4_S_ADDR_W-1:0] j;
  logic [7:0]              si;
  logic [7:0]              sj;
  logic [7:0]              f;
  logic [ADDR_W:0]         k;

  logic [7:0] dec_byte;

  assign dec_byte = f ^ rom_q;

`ifdef RC4_PRGA_CHAR_CHECK_EN
  logic byte_ok;

  rc4_char_check u_char_check (
    .char_in (dec_byte),
    .valid   (byte_ok)
  );
`endif

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      f         <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_INIT;
        end
        ST_INIT: begin
          i         <= '0;
          j         <= '0;
          k         <= '0;
          key_valid <= 1'b1;
          state     <= ST_INC_I;
        end
        ST_INC_I: begin
          i     <= i + 8'd1;
          state <= ST_RD_SI_A;
        end
        ST_RD_SI_A: state <= ST_RD_SI_B;
        ST_RD_SI_B: begin
          si    <= s_q;
          state <= ST_CALC_J;
        end
        ST_CALC_J: begin
          j     <= j + si;
          state <= ST_RD_SJ_A;
        end
        ST_RD_SJ_A: state <= ST_RD_SJ_B;
        ST_RD_SJ_B: begin
          sj    <= s_q;
          state <= ST_WR_I;
        end
        ST_WR_I:   state <= ST_WR_J;
        ST_WR_J:   state <= ST_RD_F_A;
        ST_RD_F_A: state <= ST_RD_F_B;
        ST_RD_F_B: begin
          f     <= s_q;
          state <= ST_WR_D;
        end
        ST_WR_D: begin
`ifdef RC4_PRGA_CHAR_CHECK_EN
          // The offending byte is still written; the run just stops here.
          if (!byte_ok) begin
            key_valid <= 1'b0;
            state     <= ST_DONE;
          end else begin
            state <= ST_CHECK;
          end
`else
          state <= ST_CHECK;
`endif
        end
        ST_CHECK: begin
          k     <= k + K_ONE;
          state <= (k == K_LAST) ? ST_DONE : ST_INC_I;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // s_RAM and output-RAM controls are pure decodes of the current state.
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    d_data    = '0;
    d_wren    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_RD_SI_A, ST_RD_SI_B: s_address = i;
      ST_RD_SJ_A, ST_RD_SJ_B: s_address = j;
      ST_WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      ST_WR_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      ST_RD_F_A, ST_RD_F_B: s_address = si + sj;
      ST_WR_D: begin
        d_data = dec_byte;
        d_wren = 1'b1;
      end
      ST_DONE: finish = 1'b1;
      default: ;
    endcase
  end

  assign rom_address = k[ADDR_W-1:0];
  assign d_address   = k[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
// ----------------------------------------------------------------------------
// tb_rc4_prga_decrypt - directed bench for rc4_prga_decrypt (4- and 32-byte).
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rc4_prga_decrypt;

`ifdef RC4_PRGA_CHAR_CHECK_EN
  localparam logic [7:0] KNOWN_ENC = 8'h61;
  localparam logic [7:0] WRAP_ENC0 = 8'h9F;
`else
  localparam logic [7:0] KNOWN_ENC = 8'h00;
  localparam logic [7:0] WRAP_ENC0 = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start4, finish4, key_valid4, s_wren4, d_wren4;
  logic [7:0] s_addr4, s_data4, s_q4, rom_q4, d_data4;
  logic [1:0] rom_addr4, d_addr4;

  logic       start32, finish32, key_valid32, s_wren32, d_wren32;
  logic [7:0] s_addr32, s_data32, s_q32, rom_q32, d_data32;
  logic [4:0] rom_addr32, d_addr32;

  logic [7:0] s4  [256];
  logic [7:0] s32 [256];
  logic [7:0] s4_img  [256];
  logic [7:0] s32_img [256];
  logic [7:0] e4  [4];
  logic [7:0] e32 [32];
  logic [7:0] d4  [4];
  logic [7:0] d32 [32];
  logic       load4, load32;

  logic [7:0] m_s [256];
  logic [7:0] mi, mj;
  logic [7:0] p [32];

  int errors = 0;
  int checks = 0;

  rc4_prga_decrypt #(.MSG_LEN(4), .ADDR_W(2)) u4 (
    .clock(clk), .i_reset(rst), .start(start4), .finish(finish4),
    .key_valid(key_valid4), .s_address(s_addr4), .s_data(s_data4),
    .s_wren(s_wren4), .s_q(s_q4), .rom_address(rom_addr4), .rom_q(rom_q4),
    .d_address(d_addr4), .d_data(d_data4), .d_wren(d_wren4)
  );

  rc4_prga_decrypt #(.MSG_LEN(32), .ADDR_W(5)) u32 (
    .clock(clk), .i_reset(rst), .start(start32), .finish(finish32),
    .key_valid(key_valid32), .s_address(s_addr32), .s_data(s_data32),
    .s_wren(s_wren32), .s_q(s_q32), .rom_address(rom_addr32), .rom_q(rom_q32),
    .d_address(d_addr32), .d_data(d_data32), .d_wren(d_wren32)
  );

  // Synchronous-read memories; a load pulse copies the S image and blanks D.
  always @(posedge clk) begin
    if (load4) begin
      s4 <= s4_img;
      for (int a = 0; a < 4; a++) d4[a] <= 8'hEE;
    end else begin
      if (s_wren4) s4[s_addr4] <= s_data4;
      if (d_wren4) d4[d_addr4] <= d_data4;
    end
    s_q4   <= s4[s_addr4];
    rom_q4 <= e4[rom_addr4];
  end

  always @(posedge clk) begin
    if (load32) begin
      s32 <= s32_img;
      for (int a = 0; a < 32; a++) d32[a] <= 8'hEE;
    end else begin
      if (s_wren32) s32[s_addr32] <= s_data32;
      if (d_wren32) d32[d_addr32] <= d_data32;
    end
    s_q32   <= s32[s_addr32];
    rom_q32 <= e32[rom_addr32];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_byte(output logic [7:0] ks);
    logic [7:0] t, fa;
    mi = mi + 8'd1;
    mj = mj + m_s[mi];
    t = m_s[mi];
    m_s[mi] = m_s[mj];
    m_s[mj] = t;
    fa = m_s[mi] + m_s[mj];
    ks = m_s[fa];
  endtask

  task automatic shuffle32();
    logic [7:0] t;
    for (int a = 0; a < 256; a++) s32_img[a] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      int b;
      b = $urandom_range(a, 0);
      t = s32_img[a];
      s32_img[a] = s32_img[b];
      s32_img[b] = t;
    end
  endtask

  task automatic make_text32();
    for (int a = 0; a < 32; a++) begin
      int r;
      r = $urandom_range(26, 0);
      p[a] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
    end
  endtask

  // Encrypt p[] under the keystream of s32_img; leaves the final S in m_s.
  task automatic make_enc32();
    logic [7:0] ks;
    m_s = s32_img;
    mi = 8'd0;
    mj = 8'd0;
    for (int a = 0; a < 32; a++) begin
      model_byte(ks);
      e32[a] = ks ^ p[a];
    end
  endtask

  task automatic load(input bit big);
    if (big) load32 = 1'b1; else load4 = 1'b1;
    @(posedge clk); #1;
    load4  = 1'b0;
    load32 = 1'b0;
  endtask

  // Pulse start (sampled at edge 0), optionally pulse again at pulse_edge,
  // and return the edge after which finish was seen plus write-pulse counts.
  task automatic run(input bit big, input int pulse_edge, input int budget,
                     output int fin_edge, output int sw, output int dw);
    fin_edge = -1;
    sw = 0;
    dw = 0;
    if (big) start32 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4  = 1'b0;
    start32 = 1'b0;
    for (int e = 1; e <= budget && fin_edge < 0; e++) begin
      if (e == pulse_edge) begin
        if (big) start32 = 1'b1; else start4 = 1'b1;
      end
      @(posedge clk); #1;
      start4  = 1'b0;
      start32 = 1'b0;
      sw += big ? int'(s_wren32) : int'(s_wren4);
      dw += big ? int'(d_wren32) : int'(d_wren4);
      if (big ? finish32 : finish4) fin_edge = e;
    end
    chk("finish_within_budget", 32'(fin_edge >= 0), 32'd1);
    @(posedge clk); #1;
    chk("finish_single_cycle", 32'(big ? finish32 : finish4), 32'd0);
  endtask

  typedef struct {
    string      name;
    bit         is_s;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t       kv [9];
    int         fe, sw, dw, bad, n;
    logic [7:0] ks;

    kv[0] = '{"known_d0", 1'b0, 0, 8'h02};
    kv[1] = '{"known_d1", 1'b0, 1, 8'h05};
    kv[2] = '{"known_d2", 1'b0, 2, 8'h07};
    kv[3] = '{"known_d3", 1'b0, 3, 8'h0D};
    kv[4] = '{"known_s2", 1'b1, 2, 8'h03};
    kv[5] = '{"known_s3", 1'b1, 3, 8'h05};
    kv[6] = '{"known_s4", 1'b1, 4, 8'h09};
    kv[7] = '{"known_s5", 1'b1, 5, 8'h02};
    kv[8] = '{"known_s9", 1'b1, 9, 8'h04};

    rst = 1'b1;
    start4 = 1'b0;
    start32 = 1'b0;
    load4 = 1'b0;
    load32 = 1'b0;
    for (int a = 0; a < 256; a++) begin
      s4_img[a]  = 8'(a);
      s32_img[a] = 8'(a);
    end
    for (int a = 0; a < 32; a++) e32[a] = 8'h00;
    for (int a = 0; a < 4; a++) e4[a] = KNOWN_ENC;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_finish4", 32'(finish4), 32'd0);
    chk("reset_key_valid4", 32'(key_valid4), 32'd0);
    chk("reset_outputs4", 32'({s_wren4, d_wren4, s_addr4, s_data4, d_data4, rom_addr4, d_addr4}), 32'd0);
    chk("reset_finish32", 32'(finish32), 32'd0);
    chk("reset_key_valid32", 32'(key_valid32), 32'd0);
    chk("reset_outputs32", 32'({s_wren32, d_wren32, s_addr32, s_data32, d_data32}), 32'd0);
    chk("reset_addr32", 32'({rom_addr32, d_addr32}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known keystream from identity S.
    load(1'b0);
    run(1'b0, 0, 100, fe, sw, dw);
    chk("known_finish_edge", fe, 49);
    chk("known_s_wren_count", sw, 8);
    chk("known_d_wren_count", dw, 4);
    chk("known_key_valid", 32'(key_valid4), 32'd1);
    foreach (kv[v]) begin
      if (kv[v].is_s) chk(kv[v].name, 32'(s4[kv[v].addr]), 32'(kv[v].exp));
      else            chk(kv[v].name, 32'(d4[kv[v].addr]), 32'(kv[v].exp ^ KNOWN_ENC));
    end

    // j and f-address wrap: s[1]=FF gives j=FF and f-address FE.
    s4_img[1] = 8'hFF;
    m_s = s4_img;
    mi = 8'd0;
    mj = 8'd0;
    for (int a = 0; a < 4; a++) begin
      model_byte(ks);
      e4[a] = ks ^ 8'h61;
    end
    e4[0] = WRAP_ENC0;
    load(1'b0);
    run(1'b0, 0, 100, fe, sw, dw);
    chk("wrap_finish_edge", fe, 49);
    chk("wrap_d0", 32'(d4[0]), 32'(8'hFE ^ WRAP_ENC0));
    chk("wrap_d3", 32'(d4[3]), 32'h61);

    // Full length, random S and text, with an ignored start at edge 100.
    shuffle32();
    make_text32();
    make_enc32();
    load(1'b1);
    run(1'b1, 100, 500, fe, sw, dw);
    chk("full_finish_edge", fe, 385);
    chk("full_s_wren_count", sw, 64);
    chk("full_d_wren_count", dw, 32);
    chk("full_key_valid", 32'(key_valid32), 32'd1);
    bad = 0;
    for (int a = 0; a < 32; a++) if (d32[a] !== p[a]) bad++;
    chk("full_d_bytes", bad, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (s32[a] !== m_s[a]) bad++;
    chk("full_final_s", bad, 0);

    // Start held high: restore S during DONE, expect an identical second run.
    for (int a = 0; a < 256; a++) s4_img[a] = 8'(a);
    for (int a = 0; a < 4; a++) e4[a] = KNOWN_ENC;
    load(1'b0);
    start4 = 1'b1;
    fe = -1;
    for (int e = 0; e <= 100 && fe < 0; e++) begin
      @(posedge clk); #1;
      if (finish4) fe = e;
    end
    chk("restart_first_finish_edge", fe, 49);
    load4 = 1'b1;
    n = 0;
    fe = -1;
    for (int e = 1; e <= 100 && fe < 0; e++) begin
      @(posedge clk); #1;
      load4 = 1'b0;
      if (e == 6) start4 = 1'b0;
      if (finish4) fe = e;
    end
    start4 = 1'b0;
    chk("restart_second_finish_gap", fe, 51);
    bad = 0;
    for (int a = 0; a < 4; a++) if (d4[a] !== (kv[a].exp ^ KNOWN_ENC)) bad++;
    chk("restart_d_identical", bad, 0);
    chk("restart_s3", 32'(s4[3]), 32'h05);
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      n += int'(s_wren4) + int'(finish4);
    end
    chk("restart_no_third_run", n, 0);

    // Reset asserted during byte 3 WR_I (the cycle after edge 43).
    shuffle32();
    make_text32();
    make_enc32();
    load(1'b1);
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    chk("midrst_in_wr_i", 32'({s_wren32, s_addr32}), 32'({1'b1, 8'(3'd4)}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_wrens_finish", 32'({s_wren32, d_wren32, finish32}), 32'd0);
    chk("midrst_key_valid", 32'(key_valid32), 32'd0);
    chk("midrst_idle_outputs", 32'({s_addr32, rom_addr32}), 32'd0);
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      n += int'(s_wren32) + int'(d_wren32) + int'(finish32);
    end
    chk("midrst_no_writes", n, 0);
    m_s = s32_img;
    mi = 8'd0;
    mj = 8'd0;
    repeat (3) model_byte(ks);
    mi = mi + 8'd1;
    mj = mj + m_s[mi];
    m_s[mi] = m_s[mj];
    bad = 0;
    for (int a = 0; a < 256; a++) if (s32[a] !== m_s[a]) bad++;
    chk("midrst_partial_s", bad, 0);
    s32_img = m_s;
    make_text32();
    make_enc32();
    load(1'b1);
    run(1'b1, 0, 500, fe, sw, dw);
    chk("midrst_rerun_finish_edge", fe, 385);
    bad = 0;
    for (int a = 0; a < 32; a++) if (d32[a] !== p[a]) bad++;
    chk("midrst_rerun_d_bytes", bad, 0);

    // d[1]=0x41: aborts with the check built in, otherwise full run.
    shuffle32();
    for (int a = 0; a < 32; a++) p[a] = 8'h61;
    p[1] = 8'h41;
    make_enc32();
    load(1'b1);
    run(1'b1, 0, 500, fe, sw, dw);
    chk("char_d0", 32'(d32[0]), 32'h61);
    chk("char_d1", 32'(d32[1]), 32'h41);
`ifdef RC4_PRGA_CHAR_CHECK_EN
    chk("char_finish_edge", fe, 24);
    chk("char_key_valid", 32'(key_valid32), 32'd0);
    chk("char_d_wren_count", dw, 2);
    bad = 0;
    for (int a = 2; a < 32; a++) if (d32[a] !== 8'hEE) bad++;
    chk("char_rest_untouched", bad, 0);
`else
    chk("char_finish_edge", fe, 385);
    chk("char_key_valid", 32'(key_valid32), 32'd1);
    chk("char_d_wren_count", dw, 32);
    bad = 0;
    for (int a = 0; a < 32; a++) if (d32[a] !== p[a]) bad++;
    chk("char_all_bytes", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
